// File: rtl/uart_word_rx_if.sv
// Handshake bundle between the UART word receiver and its consumer.
// The serial line rides along so the receiver needs a single bus port.
interface uart_word_rx_if;
  logic        data_in;
  logic        read_en;
  logic [31:0] data_in_parallel;
  logic        ready_to_read;
  logic        frame_error;
  logic        overrun;

  modport slave (
    input  data_in,
    input  read_en,
    output data_in_parallel,
    output ready_to_read,
    output frame_error,
    output overrun
  );

  modport master (
    output data_in,
    output read_en,
    input  data_in_parallel,
    input  ready_to_read,
    input  frame_error,
    input  overrun
  );
endinterface

// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that packs four bytes (LSB byte first) into a 32-bit word
// and offers it through a ready_to_read / read_en handshake.
module uart_word_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic          clk,
  input  logic          reset,
  uart_word_rx_if.slave bus
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
  localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e            state_q;
  logic              sync1_q;
  logic              rx_s_q;
  logic [CNT_W-1:0]  clk_cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic [1:0]        byte_cnt_q;
  logic [31:0]       buf_q;
  logic              done_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              frame_error_q;
  logic [31:0]       word_q;
  logic              ready_q;
  logic              overrun_q;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= bus.data_in;
      rx_s_q  <= sync1_q;
    end
  end

  // Bit-level receiver, word assembly and partial-word timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      clk_cnt_q     <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      byte_cnt_q    <= '0;
      buf_q         <= '0;
      done_q        <= 1'b0;
      to_cnt_q      <= '0;
      frame_error_q <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q   <= S_START;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            to_cnt_q  <= '0;
          end else if (byte_cnt_q != 2'd0) begin
            if (to_cnt_q == TO_LAST) begin
              byte_cnt_q <= '0;
              to_cnt_q   <= '0;
            end else begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
          end else begin
            to_cnt_q <= '0;
          end
        end
        S_START: begin
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= S_IDLE;
            if (rx_s_q) begin
              buf_q[{byte_cnt_q, 3'b000} +: 8] <= shift_q;
              byte_cnt_q <= byte_cnt_q + 2'd1;
              done_q     <= (byte_cnt_q == 2'd3);
            end else begin
              frame_error_q <= 1'b1;
              byte_cnt_q    <= '0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output word register; a same-cycle read makes room for the new word.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q    <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (done_q) begin
        if (!ready_q || bus.read_en) begin
          word_q  <= buf_q;
          ready_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (ready_q && bus.read_en) begin
        ready_q <= 1'b0;
      end
    end
  end

  assign bus.data_in_parallel = word_q;
  assign bus.ready_to_read    = ready_q;
  assign bus.frame_error      = frame_error_q;
  assign bus.overrun          = overrun_q;

endmodule
